// File: rtl/eka_control_fsm.sv
// Multi-cycle sequencer for the Eka core: FETCH -> DECODE -> EXEC -> [MEM] -> WB,
// with halt at instruction boundaries and a sticky FAULT on bus timeout or illegal opcode.
module eka_control_fsm #(
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter int unsigned TMO_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       halt_req,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_load,
    input  logic       dec_write_en,
    input  logic       dec_mem_read_en,
    input  logic       dec_mem_write_en,
    input  logic       dec_branch_inst,
    input  logic       dec_jump_inst,
    input  logic       dec_illegal,
    input  logic       branch_taken,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    output logic       rf_write_en,
    output logic [1:0] rf_wdata_sel,
    output logic       pc_write_en,
    output logic       pc_sel,
    output logic       retire,
    output logic       halted,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_FAULT
    } state_t;

    localparam logic [1:0]     SEL_ALU   = 2'b00;
    localparam logic [1:0]     SEL_LOAD  = 2'b01;
    localparam logic [1:0]     SEL_PC4   = 2'b10;
    localparam bit             TMO_EN    = (ACK_TIMEOUT != 0);
    localparam logic [TMO_W:0] TMO_LIMIT = (TMO_W+1)'(ACK_TIMEOUT);

    state_t           state, state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_expire;

    // The counter holds completed wait cycles, so this fires on the
    // ACK_TIMEOUT-th request cycle that sees no ack.
    assign tmo_expire = TMO_EN && (({1'b0, tmo_cnt} + (TMO_W+1)'(1)) == TMO_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any state change clears the counter, which covers entry into FETCH and MEM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state_nxt != state) begin
            tmo_cnt <= '0;
        end else if (state == S_FETCH || state == S_MEM) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    always_comb begin
        state_nxt    = state;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_write_en  = 1'b0;
        rf_wdata_sel = SEL_ALU;
        pc_write_en  = 1'b0;
        pc_sel       = 1'b0;
        retire       = 1'b0;
        halted       = 1'b0;
        fault        = 1'b0;

        case (state)
            S_IDLE: begin
                halted = 1'b1;
                if (!halt_req) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end else if (tmo_expire) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                state_nxt = dec_illegal ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                state_nxt = (dec_mem_read_en || dec_mem_write_en) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write_en;
                if (dmem_ack) begin
                    state_nxt = S_WB;
                end else if (tmo_expire) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                rf_write_en  = dec_write_en;
                rf_wdata_sel = dec_jump_inst   ? SEL_PC4  :
                               dec_mem_read_en ? SEL_LOAD : SEL_ALU;
                pc_write_en  = 1'b1;
                pc_sel       = dec_jump_inst | (dec_branch_inst & branch_taken);
                retire       = 1'b1;
                state_nxt    = halt_req ? S_IDLE : S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_eka_control_fsm.sv
// Directed bench for eka_control_fsm: instruction classes, wait states,
// timeout, illegal opcode, halt and async reset.
module tb_eka_control_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       halt_req;
    logic       imem_req;
    logic       imem_ack;
    logic       ir_load;
    logic       dec_write_en;
    logic       dec_mem_read_en;
    logic       dec_mem_write_en;
    logic       dec_branch_inst;
    logic       dec_jump_inst;
    logic       dec_illegal;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic       rf_write_en;
    logic [1:0] rf_wdata_sel;
    logic       pc_write_en;
    logic       pc_sel;
    logic       retire;
    logic       halted;
    logic       fault;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    eka_control_fsm #(.ACK_TIMEOUT(4), .TMO_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .halt_req         (halt_req),
        .imem_req         (imem_req),
        .imem_ack         (imem_ack),
        .ir_load          (ir_load),
        .dec_write_en     (dec_write_en),
        .dec_mem_read_en  (dec_mem_read_en),
        .dec_mem_write_en (dec_mem_write_en),
        .dec_branch_inst  (dec_branch_inst),
        .dec_jump_inst    (dec_jump_inst),
        .dec_illegal      (dec_illegal),
        .branch_taken     (branch_taken),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_ack         (dmem_ack),
        .rf_write_en      (rf_write_en),
        .rf_wdata_sel     (rf_wdata_sel),
        .pc_write_en      (pc_write_en),
        .pc_sel           (pc_sel),
        .retire           (retire),
        .halted           (halted),
        .fault            (fault)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic w, input logic r, input logic s,
                           input logic b, input logic j, input logic ill);
        dec_write_en     = w;
        dec_mem_read_en  = r;
        dec_mem_write_en = s;
        dec_branch_inst  = b;
        dec_jump_inst    = j;
        dec_illegal      = ill;
    endtask

    initial begin
        reset_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        branch_taken = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_halted", halted, 1);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pc_we", pc_write_en, 0);
        chk("rst_retire", retire, 0);
        step(); step();

        // Leave reset with halt_req high: must wait in IDLE
        reset_n = 1'b1; halt_req = 1'b1;
        step();
        chk("idle_hold_halted", halted, 1);
        chk("idle_hold_imem_req", imem_req, 0);
        halt_req = 1'b0;

        // ADDI, ack on the first FETCH cycle
        step();
        chk("addi_f_imem_req", imem_req, 1);
        chk("addi_f_ir_load_noack", ir_load, 0);
        imem_ack = 1'b1; set_dec(1, 0, 0, 0, 0, 0);
        #1;
        chk("addi_f_ir_load", ir_load, 1);
        chk("addi_f_halted", halted, 0);
        step();
        chk("addi_d_imem_req", imem_req, 0);
        chk("addi_d_ir_load_ignored", ir_load, 0);
        step();
        chk("addi_e_pc_we", pc_write_en, 0);
        chk("addi_e_retire", retire, 0);
        step();
        chk("addi_wb_retire", retire, 1);
        chk("addi_wb_rf_we", rf_write_en, 1);
        chk("addi_wb_sel", rf_wdata_sel, 2'b00);
        chk("addi_wb_pc_we", pc_write_en, 1);
        chk("addi_wb_pc_sel", pc_sel, 0);

        // LW, dmem_ack after 3 wait cycles
        step();
        chk("lw_f_imem_req", imem_req, 1);
        set_dec(1, 1, 0, 0, 0, 0);
        step(); step();
        chk("lw_e_dmem_req", dmem_req, 0);
        step();
        chk("lw_m1_dmem_req", dmem_req, 1);
        chk("lw_m1_dmem_we", dmem_we, 0);
        chk("lw_m1_imem_req", imem_req, 0);
        step();
        chk("lw_m2_dmem_req", dmem_req, 1);
        step();
        chk("lw_m3_dmem_req", dmem_req, 1);
        step();
        chk("lw_m4_dmem_req", dmem_req, 1);
        chk("lw_m4_pc_we", pc_write_en, 0);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        #1;
        chk("lw_wb_dmem_req", dmem_req, 0);
        chk("lw_wb_fault", fault, 0);
        chk("lw_wb_retire", retire, 1);
        chk("lw_wb_rf_we", rf_write_en, 1);
        chk("lw_wb_sel", rf_wdata_sel, 2'b01);
        chk("lw_wb_pc_sel", pc_sel, 0);

        // SW, same wait timing
        step();
        set_dec(0, 0, 1, 0, 0, 0);
        step(); step(); step();
        chk("sw_m1_dmem_req", dmem_req, 1);
        chk("sw_m1_dmem_we", dmem_we, 1);
        step(); step(); step();
        chk("sw_m4_dmem_we", dmem_we, 1);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        #1;
        chk("sw_wb_retire", retire, 1);
        chk("sw_wb_rf_we", rf_write_en, 0);
        chk("sw_wb_pc_we", pc_write_en, 1);

        // BEQ taken
        step();
        set_dec(0, 0, 0, 1, 0, 0);
        step(); step(); step();
        branch_taken = 1'b1;
        #1;
        chk("beqt_wb_retire", retire, 1);
        chk("beqt_wb_pc_sel", pc_sel, 1);
        chk("beqt_wb_rf_we", rf_write_en, 0);

        // BEQ not taken
        step();
        branch_taken = 1'b0;
        step(); step(); step();
        chk("beqn_wb_retire", retire, 1);
        chk("beqn_wb_pc_sel", pc_sel, 0);

        // JAL
        step();
        set_dec(1, 0, 0, 0, 1, 0);
        step(); step(); step();
        chk("jal_wb_pc_sel", pc_sel, 1);
        chk("jal_wb_rf_we", rf_write_en, 1);
        chk("jal_wb_sel", rf_wdata_sel, 2'b10);

        // ADDI with halt raised in EXEC
        step();
        set_dec(1, 0, 0, 0, 0, 0);
        step(); step();
        halt_req = 1'b1;
        step();
        chk("halt_wb_retire", retire, 1);
        step();
        chk("halt_idle_halted", halted, 1);
        chk("halt_idle_imem_req", imem_req, 0);
        step();
        chk("halt_idle2_halted", halted, 1);
        halt_req = 1'b0;
        step();
        chk("halt_resume_imem_req", imem_req, 1);
        chk("halt_resume_halted", halted, 0);

        // Illegal opcode
        set_dec(0, 0, 0, 0, 0, 1);
        step();
        step();
        chk("ill_fault", fault, 1);
        chk("ill_retire", retire, 0);
        chk("ill_pc_we", pc_write_en, 0);
        chk("ill_halted", halted, 0);
        dmem_ack = 1'b1;
        step();
        chk("ill_sticky_fault", fault, 1);
        chk("ill_sticky_imem_req", imem_req, 0);
        dmem_ack = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("ill_rst_halted", halted, 1);
        chk("ill_rst_fault", fault, 0);

        // Fetch timeout with ACK_TIMEOUT=4
        set_dec(0, 0, 0, 0, 0, 0);
        imem_ack = 1'b0;
        reset_n = 1'b1;
        step();
        chk("tmo_c1_imem_req", imem_req, 1);
        step(); step(); step();
        chk("tmo_c4_imem_req", imem_req, 1);
        chk("tmo_c4_fault", fault, 0);
        step();
        chk("tmo_fault", fault, 1);
        chk("tmo_imem_req", imem_req, 0);
        imem_ack = 1'b1;
        step();
        chk("tmo_sticky_fault", fault, 1);
        chk("tmo_sticky_ir_load", ir_load, 0);
        reset_n = 1'b0;
        #1;
        chk("tmo_rst_halted", halted, 1);
        chk("tmo_rst_fault", fault, 0);

        // Async reset during MEM drops dmem_req at once
        set_dec(1, 1, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(); step(); step(); step();
        chk("rmem_dmem_req", dmem_req, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmem_dmem_req_drop", dmem_req, 0);
        chk("rmem_halted", halted, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
